// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and sizing constants for imem_loader
package imem_loader_pkg;

  localparam int DEFAULT_DEPTH  = 128;
  localparam int DEFAULT_ADDR_W = 7;
  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len, input int depth);
    return (int'(len) > depth) ? LEN_W'(depth) : len;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - big-endian byte-to-word assembler
// IMEM_LOADER_CHECKSUM_EN adds a running XOR of every accepted byte.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        full_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]  xor_o
`endif
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [23:0] word_q;
  logic [1:0]  cnt_q;

  // word_o already carries the byte on byte_i, so the word is complete in the cycle the 4th byte is taken
  assign word_o = {word_q, byte_i};
  assign full_o = (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (accept_i) begin
      word_q <= {word_q[15:0], byte_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  assign xor_o = xor_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      xor_q <= '0;
    end else if (accept_i) begin
      xor_q <= xor_q ^ byte_i;
    end
  end
`endif

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
// IMEM_LOADER_CHECKSUM_EN enables the trailing XOR checksum byte and err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [LEN_W-1:0]  eff_len_q;
  logic [LEN_W-1:0]  eff_len_d;
  logic [LEN_W-1:0]  idx_next_d;
  logic [ADDR_W-1:0] idx_q;
  logic              in_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              clear_d;
  logic              accept_d;
  logic              pk_full;
  logic [31:0]       pk_word;

  assign eff_len_d  = clamp_len(len, DEPTH);
  assign idx_next_d = LEN_W'(idx_q) + LEN_W'(1);
  assign clear_d    = (state_q == S_IDLE) && start;
  assign accept_d   = (state_q == S_RECV) && in_valid && in_ready_q;

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] pk_xor;
  logic       err_q;

  assign err = err_q;

  word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear_d),
    .accept_i (accept_d),
    .byte_i   (in_data),
    .word_o   (pk_word),
    .full_o   (pk_full),
    .xor_o    (pk_xor)
  );
`else
  assign err = 1'b0;

  word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (clear_d),
    .accept_i (accept_d),
    .byte_i   (in_data),
    .word_o   (pk_word),
    .full_o   (pk_full)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      eff_len_q  <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err_q      <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            eff_len_q <= eff_len_d;
            idx_q     <= '0;
            done_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err_q     <= 1'b0;
`endif
            if (eff_len_d == '0) begin
              state_q <= S_DONE;
            end else begin
              state_q    <= S_RECV;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (accept_d && pk_full) begin
            state_q    <= S_WRITE;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            wr_addr_q  <= idx_q;
            wr_data_q  <= pk_word;
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + ADDR_W'(1);
          if (idx_next_d == eff_len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_q    <= S_CHECK;
            in_ready_q <= 1'b1;
`else
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
`endif
          end else begin
            state_q    <= S_RECV;
            in_ready_q <= 1'b1;
          end
        end
        S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (in_valid) begin
            err_q      <= (in_data != pk_xor);
            state_q    <= S_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a word-level write model
module tb_imem_loader;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int TRL_EXTRA = 1;
`else
  localparam int TRL_EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        len;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_writes = 0;
  wr_t        exp_q[$];
  wr_t        exp_e;
  logic [7:0] src_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected writes: word w is bytes 4w..4w+3 MSB first, at address w, for min(n, DEPTH) words.
  function automatic void model_load(input int n, input logic [7:0] bytes[$]);
    int eff;
    eff = (n > DEPTH) ? DEPTH : n;
    exp_q.delete();
    for (int w = 0; w < eff; w++) begin
      wr_t e;
      e.addr = w % DEPTH;
      e.data = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
      exp_q.push_back(e);
    end
  endfunction

`ifdef IMEM_LOADER_CHECKSUM_EN
  function automatic logic [7:0] xor_of(input logic [7:0] b[$]);
    logic [7:0] x;
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    return x;
  endfunction
`endif

  task automatic add_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    src_q.push_back(xor_of(src_q));
`endif
  endtask

  logic [ADDR_W-1:0] prev_addr;
  logic [31:0]       prev_data;
  bit                prev_ok = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      prev_ok = 1'b0;
    end else begin
      check("hold_vs_busy", cpu_hold, busy);
      if (wr_en) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data 0x%h, required no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", wr_addr, exp_e.addr);
          check("wr_data", wr_data, exp_e.data);
        end
      end else if (prev_ok) begin
        check("wr_addr_stable", wr_addr, prev_addr);
        check("wr_data_stable", wr_data, prev_data);
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      check("err_tied_low", err, 0);
`endif
      prev_addr = wr_addr;
      prev_data = wr_data;
      prev_ok   = 1'b1;
    end
  end

  task automatic run_load(input string tag, input int n, input bit toggle, output int lat, output int nw);
    int   t0, done_cyc, budget, eff, trl, left0;
    bit   acc, phase, seen_busy;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] payload[$];
    bit         exp_err;
`endif
    model_load(n, src_q);
    eff   = (n > DEPTH) ? DEPTH : n;
    trl   = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = 1'b0;
    if (eff > 0) begin
      trl     = 1;
      payload = src_q[0:4*eff-1];
      exp_err = (src_q[4*eff] != xor_of(payload));
    end
`endif
    left0     = src_q.size();
    n_writes  = 0;
    done_cyc  = -1;
    seen_busy = 1'b0;
    phase     = 1'b1;
    budget    = 10 * n + 60;
    start     = 1'b1;
    len       = n[7:0];
    t0        = cyc;
    in_valid  = (src_q.size() > 0);
    in_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (busy) seen_busy = 1'b1;
      if (cyc > t0 && done) done_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) void'(src_q.pop_front());
      phase    = toggle ? ~phase : 1'b1;
      in_valid = phase && (src_q.size() > 0);
      in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
    lat = done_cyc - t0;
    if (done_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: done not seen in %0d cycles, required done", tag, budget);
    end else if (!toggle) begin
      check({tag, "_latency"}, lat, (eff == 0) ? 2 : 5 * eff + 1 + trl);
    end
    repeat (3) begin
      @(negedge clk);
      check({tag, "_no_ready_after_done"}, in_ready, 0);
      check({tag, "_done_level"}, done, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nw = n_writes;
    check({tag, "_write_count"}, nw, eff);
    check({tag, "_bytes_left"}, src_q.size(), left0 - 4 * eff - trl);
    check({tag, "_model_drained"}, exp_q.size(), 0);
    check({tag, "_busy_seen"}, seen_busy, (eff > 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_err"}, err, exp_err);
`endif
  endtask

  int lat, nw, cnt;
  bit acc;

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    len      = 8'd1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_under_reset_ignored_ready", in_ready, 0);
    check("start_under_reset_ignored_busy", busy, 0);
    @(posedge clk);
    #1;

    // back-to-back two-word load
    src_q = '{8'h3C, 8'h01, 8'h10, 8'h00, 8'h8C, 8'h22, 8'h00, 8'h04};
    model_load(2, src_q);
    check("model_pin_w0", exp_q[0].data, 32'h3C011000);
    check("model_pin_w1", exp_q[1].data, 32'h8C220004);
    add_trailer();
    run_load("b2b", 2, 1'b0, lat, nw);
    check("b2b_latency_literal", lat, 11 + TRL_EXTRA);
    check("b2b_wr_en_cycles", nw, 2);

    // in_valid toggling every cycle
    src_q = '{8'h20, 8'h08, 8'h00, 8'h05};
    model_load(1, src_q);
    check("model_pin_toggle", exp_q[0].data, 32'h20080005);
    add_trailer();
    run_load("toggle", 1, 1'b1, lat, nw);
    check("toggle_write_count_literal", nw, 1);

    // zero length
    src_q.delete();
    run_load("len0", 0, 1'b0, lat, nw);
    check("len0_latency_literal", lat, 2);

    // oversize length clamps to DEPTH; the 129th word is left in the source
    src_q.delete();
    for (int i = 0; i < 4 * DEPTH; i++) src_q.push_back(8'((i * 37 + 11) ^ (i >> 3)));
    add_trailer();
    for (int i = 0; i < 4; i++) src_q.push_back(8'hA0 + 8'(i));
    run_load("clamp", 200, 1'b0, lat, nw);
    check("clamp_writes_literal", nw, 128);

    // reset after the 2nd byte of word 1
    src_q.delete();
    for (int i = 0; i < 12; i++) src_q.push_back(8'h50 + 8'(i));
    model_load(1, src_q);
    n_writes = 0;
    start    = 1'b1;
    len      = 8'd3;
    in_valid = 1'b1;
    in_data  = src_q[0];
    cnt      = 0;
    for (int i = 0; i < 100 && cnt < 6; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (acc) begin
        void'(src_q.pop_front());
        cnt++;
      end
      in_data = src_q[0];
    end
    check("rst_mid_bytes_taken", cnt, 6);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cpu_hold", cpu_hold, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = src_q[0];
    repeat (4) begin
      @(negedge clk);
      check("rst_mid_idle_no_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rst_mid_writes", n_writes, 1);
    check("rst_mid_model_drained", exp_q.size(), 0);

    src_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    add_trailer();
    run_load("reload", 1, 1'b0, lat, nw);

`ifdef IMEM_LOADER_CHECKSUM_EN
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    check("model_pin_xor", xor_of(src_q), 8'h44);
    src_q.push_back(8'h44);
    run_load("ck_good", 1, 1'b0, lat, nw);
    check("ck_good_err_literal", err, 0);
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run_load("ck_bad", 1, 1'b0, lat, nw);
    check("ck_bad_err_literal", err, 1);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
